// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: handshaked pipeline stage register with flush and a
// saturating backpressure counter.
// Build option PIPE_STAGE_SKID_EN: two-entry skid variant whose in_ready is
// decoded from state flops only. Undefined: single register whose in_ready is
// out_ready || !out_valid.
module pipe_stage_hs #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CNT_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [CNT_BIT-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic             in_xfer;
  logic             out_xfer;
`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
`endif

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

`ifdef PIPE_STAGE_SKID_EN
  assign in_ready = (state_q != FULL);
`else
  assign in_ready = out_ready || !out_valid;
`endif

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Next-state and storage update; flush overrides any handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = '0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = BUSY;
            main_d  = in_data;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_xfer) begin
            state_d = FULL;
            skid_d  = in_data;
`endif
          end else if (out_xfer) begin
            // main keeps its value so out_data holds after draining
            state_d = EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL: begin
          if (out_xfer) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

  // Saturating count of cycles with valid output held off by downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_BIT'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed bench for pipe_stage_hs with a queue-based
// reference model compared every cycle, plus hand-computed literal checks.
module tb_pipe_stage_hs;

  localparam int unsigned W       = 32;
  localparam int unsigned CB      = 4;
  localparam int unsigned CNT_MAX = (1 << CB) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CB-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  pipe_stage_hs #(.WIDTH(W), .CNT_BIT(CB)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of capacity CAP, the last value shown, a counter.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_hold = '0;
  int unsigned  m_cnt  = 0;
  bit           m_pop;
  bit           m_push;

  function automatic bit m_valid();
    return mq.size() != 0;
  endfunction

  function automatic bit m_ready();
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < CAP;
`else
    return (mq.size() == 0) || out_ready;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_hold = '0;
      m_cnt  = 0;
    end else begin
      if (m_valid() && !out_ready && m_cnt != CNT_MAX) m_cnt++;
      m_pop  = m_valid() && out_ready;
      m_push = in_valid && m_ready();
      if (flush) begin
        mq.delete();
        m_hold = '0;
      end else begin
        if (m_pop) m_hold = mq.pop_front();
        if (m_push) mq.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_out_valid", 64'(out_valid), 64'(m_valid()));
      check("m_in_ready", 64'(in_ready), 64'(m_ready()));
      check("m_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      if (m_valid()) check("m_out_data", 64'(out_data), 64'(mq[0]));
      else           check("m_out_data_idle", 64'(out_data), 64'(m_hold));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // {flush, in_valid, out_ready} per cycle for a mixed traffic sequence
  logic [2:0] vec [24] = '{
    3'b011, 3'b010, 3'b010, 3'b001, 3'b011, 3'b000, 3'b011, 3'b010,
    3'b001, 3'b001, 3'b110, 3'b011, 3'b010, 3'b101, 3'b011, 3'b011,
    3'b010, 3'b000, 3'b001, 3'b011, 3'b010, 3'b010, 3'b011, 3'b010
  };

  initial begin
    #50000;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);

    // Streaming with out_ready high: each value visible right after acceptance
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      cyc();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data", 64'(out_data), 64'(i));
    end
    in_valid = 1'b0;
    cyc();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_hold", 64'(out_data), 64'h8);

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    cyc();
    in_data = 32'hB;
    cyc();
    check("bp_data", 64'(out_data), 64'hA);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_stall1", 64'(stall_cnt), 64'd1);
    in_valid = 1'b0;
    cyc();
    cyc();
    check("bp_stall3", 64'(stall_cnt), 64'd3);
    check("bp_hold", 64'(out_data), 64'hA);
    out_ready = 1'b1;
    cyc();
    check("rel_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_STAGE_SKID_EN
    check("rel_data_b", 64'(out_data), 64'hB);
    check("rel_valid", 64'(out_valid), 64'd1);
`else
    check("rel_valid", 64'(out_valid), 64'd0);
`endif
    cyc();
    check("rel_empty", 64'(out_valid), 64'd0);
    check("rel_stall", 64'(stall_cnt), 64'd3);

    // Flush while holding two entries (one in the single-register build)
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    cyc();
    in_data = 32'hB;
    cyc();
    flush = 1'b1; in_data = 32'hC;
    cyc();
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_stall", 64'(stall_cnt), 64'd5);
    check("flush_data", 64'(out_data), 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    cyc();
    check("flush_no_emit", 64'(out_valid), 64'd0);

    // Flush coinciding with transfers in and out
    in_valid = 1'b1; in_data = 32'hD;
    cyc();
    in_data = 32'hE; flush = 1'b1;
    cyc();
    check("flush_xfer_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    cyc();

    // Mixed traffic checked by the model each cycle
    for (int i = 0; i < 24; i++) begin
      flush     = vec[i][2];
      in_valid  = vec[i][1];
      out_ready = vec[i][0];
      in_data   = 32'h20 + 32'(i);
      cyc();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("mix_busy", 64'(out_valid), 64'd1);

    // Reset mid-operation, then counter saturation
    rst = 1'b1;
    cyc();
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_stall", 64'(stall_cnt), 64'd0);
    rst = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    cyc();
    in_valid = 1'b0;
    repeat (20) cyc();
    check("sat_15", 64'(stall_cnt), 64'd15);
    repeat (3) cyc();
    check("sat_hold", 64'(stall_cnt), 64'd15);
    check("sat_data", 64'(out_data), 64'h55);

    // out_ready toggle with a valid output
`ifdef PIPE_STAGE_SKID_EN
    check("tog_ready_lo", 64'(in_ready), 64'd1);
`else
    check("tog_ready_lo", 64'(in_ready), 64'd0);
`endif
    out_ready = 1'b1;
    #1;
    check("tog_ready_hi", 64'(in_ready), 64'd1);
    cyc();
    check("tog_drained", 64'(out_valid), 64'd0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
